wrr_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter, the successor to the fixed round-robin `rr_arbiter`. It grants one of `CLIENTS` requesters per cycle and lets each client hold the grant for up to its programmed weight in consecutive cycles. It keeps the stall semantics of the earlier arbiter and adds an encoded grant index with a valid flag. It sits between request sources and a shared resource; the registered, one-hot grant drives the resource mux directly.

---
 rtl/wrr_arbiter.sv | 85 ++++++++
 tb/tb_wrr_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, per-client burst of up to its weight,
// with a global stall that freezes all state.
module wrr_arbiter #(
  parameter int unsigned CLIENTS  = 8,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned IDX_W    = $clog2(CLIENTS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CLIENTS-1:0]           request,
  input  logic [CLIENTS*WEIGHT_W-1:0]  weight,
  input  logic                         stall,
  output logic [CLIENTS-1:0]           grant,
  output logic [IDX_W-1:0]             grant_id,
  output logic                         grant_valid
);

  logic [CLIENTS-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    id_q, id_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic                found;
  logic [IDX_W-1:0]    win;
  logic [WEIGHT_W-1:0] win_weight;
  logic                cont;

  // Circular search starting just after the owner; the owner itself is visited last.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= CLIENTS; i++) begin
      idx = int'(owner_q) + i;
      if (idx >= CLIENTS) idx = idx - CLIENTS;
      if (!found && request[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    win_weight = weight[int'(win)*WEIGHT_W +: WEIGHT_W];
    cont       = grant_q[owner_q] && request[owner_q] && (credit_q > WEIGHT_W'(1));

    grant_d  = grant_q;
    owner_d  = owner_q;
    id_d     = id_q;
    credit_d = credit_q;

    if (cont) begin
      credit_d = credit_q - WEIGHT_W'(1);
    end else if (found) begin
      grant_d      = '0;
      grant_d[win] = 1'b1;
      owner_d      = win;
      id_d         = win;
      // A programmed weight of zero still buys one cycle.
      credit_d     = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
    end else begin
      grant_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q  <= '0;
      owner_q  <= IDX_W'(CLIENTS - 1);
      id_q     <= '0;
      credit_q <= '0;
    end else if (!stall) begin
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      id_q     <= id_d;
      credit_q <= credit_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign grant_valid = |grant_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter with hand-computed grant sequences.
module tb_wrr_arbiter;

  localparam int unsigned CLIENTS  = 8;
  localparam int unsigned WEIGHT_W = 4;
  localparam int unsigned IDX_W    = 3;

  logic                        clock;
  logic                        reset;
  logic [CLIENTS-1:0]          request;
  logic [CLIENTS*WEIGHT_W-1:0] weight;
  logic                        stall;
  logic [CLIENTS-1:0]          grant;
  logic [IDX_W-1:0]            grant_id;
  logic                        grant_valid;

  int n_tests;
  int n_fail;

  wrr_arbiter #(
    .CLIENTS  (CLIENTS),
    .WEIGHT_W (WEIGHT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .request     (request),
    .weight      (weight),
    .stall       (stall),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_weight(input int i, input logic [WEIGHT_W-1:0] v);
    weight[i*WEIGHT_W +: WEIGHT_W] = v;
  endtask

  initial begin
    int hi_cnt;
    logic [7:0] exp_seq [8];
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    stall   = 1'b0;
    request = '0;
    weight  = {CLIENTS{4'h1}};
    #1;
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_valid", 64'(grant_valid), 64'h0);
    check("rst_id", 64'(grant_id), 64'h0);

    // Equal weights, everyone requesting: plain rotation starting at client 0.
    step();
    request = 8'hFF;
    reset   = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      check($sformatf("rr_%0d", k), 64'(grant), 64'(8'h01 << (k % 8)));
    end
    check("rr_id", 64'(grant_id), 64'h0);

    // No request: grant drops, id keeps last owner.
    request = 8'h00;
    step();
    check("idle_grant", 64'(grant), 64'h0);
    check("idle_valid", 64'(grant_valid), 64'h0);
    check("idle_id", 64'(grant_id), 64'h0);

    // weight[2]=3, weight[5]=1.
    set_weight(2, 4'd3);
    set_weight(5, 4'd1);
    request = 8'b0010_0100;
    exp_seq = '{8'd2, 8'd2, 8'd2, 8'd5, 8'd2, 8'd2, 8'd2, 8'd5};
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("wrr_id_%0d", k), 64'(grant_id), 64'(exp_seq[k]));
    end
    check("wrr_valid", 64'(grant_valid), 64'h1);

    // Client 2 (weight 4) drops request after two cycles; client 3 takes over at once.
    set_weight(2, 4'd4);
    request = 8'b0000_1100;
    step();
    check("drop_g0", 64'(grant), 64'h04);
    step();
    check("drop_g1", 64'(grant), 64'h04);
    request = 8'b0000_1000;
    step();
    check("drop_g2", 64'(grant), 64'h08);
    check("drop_id", 64'(grant_id), 64'h3);
    request = 8'h00;
    step();
    check("drop_idle", 64'(grant), 64'h0);

    // Stall for 3 cycles inside a weight-3 burst to client 4; client 6 waits.
    set_weight(4, 4'd3);
    set_weight(6, 4'd1);
    request = 8'b0101_0000;
    hi_cnt  = 0;
    step(); check("st_b0", 64'(grant), 64'h10); hi_cnt += int'(grant[4]);
    step(); check("st_b1", 64'(grant), 64'h10); hi_cnt += int'(grant[4]);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("st_frz_%0d", k), 64'(grant), 64'h10);
      hi_cnt += int'(grant[4]);
    end
    stall = 1'b0;
    step(); check("st_b2", 64'(grant), 64'h10); hi_cnt += int'(grant[4]);
    step(); check("st_next", 64'(grant), 64'h40); hi_cnt += int'(grant[4]);
    check("st_count", 64'(hi_cnt), 64'd6);
    request = 8'h00;
    step();
    check("st_idle", 64'(grant), 64'h0);

    // Stall with no grant keeps grant at zero despite requests.
    stall   = 1'b1;
    request = 8'hFF;
    step();
    check("stall_nogrant", 64'(grant), 64'h0);
    step();
    check("stall_nogrant2", 64'(grant_valid), 64'h0);
    stall = 1'b0;

    // Asynchronous reset mid-cycle while client 4 owns the grant.
    request = 8'b0001_0000;
    step();
    check("prereset", 64'(grant), 64'h10);
    request = 8'hFF;
    #2;
    reset = 1'b1;
    #1;
    check("async_grant", 64'(grant), 64'h0);
    check("async_id", 64'(grant_id), 64'h0);
    #1;
    reset = 1'b0;
    step();
    check("post_rst", 64'(grant), 64'h01);

    // Zero weight behaves as one; a sole requester keeps the grant with no bubble.
    set_weight(6, 4'd0);
    request = 8'b0100_0000;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("w0_%0d", k), 64'(grant), 64'h40);
    end
    check("w0_id", 64'(grant_id), 64'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
